sdram_responder: RTL and testbench

Synthesizable responder model of the ISSI IS42S16160G SDR SDRAM, the device end of the controller's SDRAM pin interface. It decodes the command pins each clock and tracks the init sequence, mode register and per-bank open rows. It services single-word reads with programmed CAS latency and byte-masked writes from a reduced-depth backing store, and flags protocol violations. It is used in simulation benches and on-FPGA loopback tests in place of the physical part.

---
 rtl/sdram_pkg.sv | 56 +++++
 rtl/sdram_responder_mem.sv | 34 +++
 rtl/sdram_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_sdram_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command pin encodings, responder error codes,
// init sequence states and CAS latency constants.
package sdram_pkg;

    // Command encodings as {ras_n, cas_n, we_n}; the controller uses the same set.
    typedef enum logic [2:0] {
        CMD_MRS  = 3'b000,
        CMD_REF  = 3'b001,
        CMD_PRE  = 3'b010,
        CMD_BACT = 3'b011,
        CMD_WRIT = 3'b100,
        CMD_READ = 3'b101,
        CMD_BST  = 3'b110,
        CMD_NOP  = 3'b111
    } cmd_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_INIT     = 3'd1,
        ERR_CL       = 3'd2,
        ERR_REOPEN   = 3'd3,
        ERR_CLOSED   = 3'd4,
        ERR_TRCD     = 3'd5,
        ERR_REF_OPEN = 3'd6,
        ERR_CONTEND  = 3'd7
    } err_e;

    typedef enum logic [2:0] {
        W_PALL = 3'd0,
        W_REF1 = 3'd1,
        W_REF2 = 3'd2,
        W_MRS  = 3'd3,
        READY  = 3'd4
    } init_state_e;

    localparam logic [2:0] CL_2     = 3'd2;
    localparam logic [2:0] CL_3     = 3'd3;
    localparam logic [2:0] CL_RESET = CL_3;

    // Deselected or clock-disabled cycles, and burst stop, carry no work here.
    function automatic cmd_e decode_cmd(input logic cke, input logic cs_n,
                                        input logic ras_n, input logic cas_n,
                                        input logic we_n);
        cmd_e c;
        if (!cke || cs_n) begin
            c = CMD_NOP;
        end else begin
            c = cmd_e'({ras_n, cas_n, we_n});
        end
        if (c == CMD_BST) begin
            c = CMD_NOP;
        end
        return c;
    endfunction

endpackage

// File: rtl/sdram_responder_mem.sv
// Reduced-depth backing store for the SDRAM responder: 16-bit words,
// independent byte write enables, registered read-first output.
module sdram_responder_mem #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic                  we_lo_i,
    input  logic                  we_hi_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [15:0]           wdata_i,
    output logic [15:0]           rdata_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [7:0]  mem_lo [DEPTH];
    logic [7:0]  mem_hi [DEPTH];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_lo_i) begin
                mem_lo[addr_i] <= wdata_i[7:0];
            end
            if (we_hi_i) begin
                mem_hi[addr_i] <= wdata_i[15:8];
            end
            rdata_q <= {mem_hi[addr_i], mem_lo[addr_i]};
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_responder.sv
// Device-side responder for an IS42S16160G-style SDR SDRAM: command decode,
// init tracking, bank table, CAS-latency read pipeline and protocol checks.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int ROW_WIDTH      = 13,
    parameter int COL_WIDTH      = 9,
    parameter int BANK_WIDTH     = 2,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int T_RCD          = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ROW_WIDTH-1:0]  addr,
    input  logic [BANK_WIDTH-1:0] bank_addr,
    inout  wire  [15:0]           data,
    input  logic                  clock_enable,
    input  logic                  cs_n,
    input  logic                  ras_n,
    input  logic                  cas_n,
    input  logic                  we_n,
    input  logic                  data_mask_low,
    input  logic                  data_mask_high,
    output logic                  init_done,
    output logic                  error,
    output logic [2:0]            error_code,
    output logic [15:0]           refresh_cnt
);
    localparam int NUM_BANKS  = 1 << BANK_WIDTH;
    localparam int AGE_WIDTH  = $clog2(T_RCD + 2);
    localparam int FULL_WIDTH = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;
    localparam logic [AGE_WIDTH-1:0] AGE_MAX = AGE_WIDTH'(T_RCD);

    cmd_e                  cmd;
    init_state_e           state_q, state_d;
    logic [2:0]            cl_q, cl_d;
    logic [NUM_BANKS-1:0]  open_q, open_d;
    logic [ROW_WIDTH-1:0]  row_q [NUM_BANKS];
    logic [ROW_WIDTH-1:0]  row_d [NUM_BANKS];
    logic [AGE_WIDTH-1:0]  age_q [NUM_BANKS];
    logic [AGE_WIDTH-1:0]  age_d [NUM_BANKS];
    logic [15:0]           refresh_q, refresh_d;
    logic                  init_done_q;
    logic                  error_q;
    err_e                  code_q;
    err_e                  err_now;
    logic                  do_mrs;

    logic                      mem_en;
    logic                      mem_we;
    logic [FULL_WIDTH-1:0]     full_addr;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]               mem_rdata;

    logic        rd_v0_q;
    logic        stage_v_q;
    logic [15:0] stage_data_q;
    logic        out_v_q;
    logic [15:0] out_data_q;
    logic        rd_pending;

    assign cmd = decode_cmd(clock_enable, cs_n, ras_n, cas_n, we_n);

    assign full_addr = {bank_addr, row_q[bank_addr], addr[COL_WIDTH-1:0]};
    assign mem_addr  = full_addr[MEM_ADDR_WIDTH-1:0];

    // A word counts as pending from store access until its last driven cycle.
    assign rd_pending = rd_v0_q | out_v_q | (stage_v_q & (cl_q == CL_3));

    always_comb begin
        state_d   = state_q;
        cl_d      = cl_q;
        open_d    = open_q;
        row_d     = row_q;
        refresh_d = refresh_q;
        err_now   = ERR_NONE;
        do_mrs    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            age_d[b] = (age_q[b] < AGE_MAX) ? age_q[b] + AGE_WIDTH'(1) : age_q[b];
        end

        if (state_q != READY) begin
            if (cmd != CMD_NOP) begin
                if (state_q == W_PALL && cmd == CMD_PRE && addr[10]) begin
                    state_d = W_REF1;
                    open_d  = '0;
                end else if (state_q == W_REF1 && cmd == CMD_REF) begin
                    state_d = W_REF2;
                end else if (state_q == W_REF2 && cmd == CMD_REF) begin
                    state_d = W_MRS;
                end else if (state_q == W_MRS && cmd == CMD_MRS) begin
                    state_d = READY;
                    do_mrs  = 1'b1;
                end else begin
                    err_now = ERR_INIT;
                end
            end
        end else begin
            unique case (cmd)
                CMD_MRS: do_mrs = 1'b1;
                CMD_REF: begin
                    if (|open_q) begin
                        err_now = ERR_REF_OPEN;
                    end
                    if (refresh_q != 16'hFFFF) begin
                        refresh_d = refresh_q + 16'd1;
                    end
                end
                CMD_PRE: begin
                    if (addr[10]) begin
                        open_d = '0;
                    end else begin
                        open_d[bank_addr] = 1'b0;
                    end
                end
                CMD_BACT: begin
                    if (open_q[bank_addr]) begin
                        err_now = ERR_REOPEN;
                    end
                    open_d[bank_addr] = 1'b1;
                    row_d[bank_addr]  = addr;
                    // The activating edge itself counts toward tRCD.
                    age_d[bank_addr]  = AGE_WIDTH'(1);
                end
                CMD_WRIT, CMD_READ: begin
                    if (!open_q[bank_addr]) begin
                        err_now = ERR_CLOSED;
                    end else begin
                        mem_en = 1'b1;
                        mem_we = (cmd == CMD_WRIT);
                        if (age_q[bank_addr] < AGE_MAX) begin
                            err_now = ERR_TRCD;
                        end else if (cmd == CMD_WRIT && rd_pending) begin
                            err_now = ERR_CONTEND;
                        end
                        if (addr[10]) begin
                            open_d[bank_addr] = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (do_mrs) begin
            if (addr[6:4] == CL_2 || addr[6:4] == CL_3) begin
                cl_d = addr[6:4];
            end else begin
                err_now = ERR_CL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= W_PALL;
            cl_q        <= CL_RESET;
            open_q      <= '0;
            refresh_q   <= '0;
            init_done_q <= 1'b0;
            error_q     <= 1'b0;
            code_q      <= ERR_NONE;
            for (int b = 0; b < NUM_BANKS; b++) begin
                row_q[b] <= '0;
                age_q[b] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cl_q        <= cl_d;
            open_q      <= open_d;
            row_q       <= row_d;
            age_q       <= age_d;
            refresh_q   <= refresh_d;
            init_done_q <= (state_q == READY);
            if (err_now != ERR_NONE && !error_q) begin
                error_q <= 1'b1;
                code_q  <= err_now;
            end
        end
    end

    // Store read lands at E; CL=2 presents it at E+1, CL=3 adds one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v0_q      <= 1'b0;
            stage_v_q    <= 1'b0;
            stage_data_q <= '0;
            out_v_q      <= 1'b0;
            out_data_q   <= '0;
        end else begin
            rd_v0_q      <= mem_en & ~mem_we;
            stage_v_q    <= rd_v0_q;
            stage_data_q <= mem_rdata;
            if (cl_q == CL_2) begin
                out_v_q    <= rd_v0_q;
                out_data_q <= mem_rdata;
            end else begin
                out_v_q    <= stage_v_q;
                out_data_q <= stage_data_q;
            end
        end
    end

    sdram_responder_mem #(
        .ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .en_i    (mem_en),
        .we_lo_i (mem_we & ~data_mask_low),
        .we_hi_i (mem_we & ~data_mask_high),
        .addr_i  (mem_addr),
        .wdata_i (data),
        .rdata_o (mem_rdata)
    );

    assign data        = out_v_q ? out_data_q : {16{1'bz}};
    assign init_done   = init_done_q;
    assign error       = error_q;
    assign error_code  = code_q;
    assign refresh_cnt = refresh_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: init, CAS-latency reads, masked writes,
// back-to-back reads, protocol errors and asynchronous reset.
module tb_sdram_responder;
    localparam logic [2:0] C_MRS  = 3'b000;
    localparam logic [2:0] C_REF  = 3'b001;
    localparam logic [2:0] C_PRE  = 3'b010;
    localparam logic [2:0] C_BACT = 3'b011;
    localparam logic [2:0] C_WRIT = 3'b100;
    localparam logic [2:0] C_READ = 3'b101;
    localparam logic [2:0] C_NOP  = 3'b111;
    // Undriven bus reads as all ones through the pullups.
    localparam logic [15:0] REL = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [12:0] addr = '0;
    logic [1:0]  ba = '0;
    logic        cke = 1'b1;
    logic        cs_n = 1'b0;
    logic        ras_n = 1'b1;
    logic        cas_n = 1'b1;
    logic        we_n = 1'b1;
    logic        dml = 1'b0;
    logic        dmh = 1'b0;
    logic [15:0] tb_dq = '0;
    logic        tb_dq_en = 1'b0;
    wire  [15:0] dq;
    logic        init_done;
    logic        error;
    logic [2:0]  error_code;
    logic [15:0] refresh_cnt;
    int          checks = 0;
    int          failures = 0;

    assign dq = tb_dq_en ? tb_dq : {16{1'bz}};
    for (genvar gi = 0; gi < 16; gi++) begin : g_pull
        pullup pu (dq[gi]);
    end

    always #5 clk = ~clk;

    sdram_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .addr           (addr),
        .bank_addr      (ba),
        .data           (dq),
        .clock_enable   (cke),
        .cs_n           (cs_n),
        .ras_n          (ras_n),
        .cas_n          (cas_n),
        .we_n           (we_n),
        .data_mask_low  (dml),
        .data_mask_high (dmh),
        .init_done      (init_done),
        .error          (error),
        .error_code     (error_code),
        .refresh_cnt    (refresh_cnt)
    );

    // Present one command for one edge; returns 1ns after that edge.
    task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
        {ras_n, cas_n, we_n} = c;
        ba   = b;
        addr = a;
        @(posedge clk);
        #1;
        {ras_n, cas_n, we_n} = C_NOP;
        tb_dq_en = 1'b0;
        dml = 1'b0;
        dmh = 1'b0;
        $display("cmd=%b bank=%0d addr=%h dq=%h err=%0b code=%0d", c, b, a, dq, error, error_code);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) issue(C_NOP, 2'd0, 13'h0);
    endtask

    task automatic write_word(input logic [1:0] b, input logic [12:0] a, input logic [15:0] d,
                              input logic ml, input logic mh);
        tb_dq = d;
        tb_dq_en = 1'b1;
        dml = ml;
        dmh = mh;
        issue(C_WRIT, b, a);
    endtask

    task automatic test_reset;
        checks++; if (dq !== REL) begin failures++; $display("FAIL reset_dq: got %h want %h", dq, REL); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b want 0", error); end
        checks++; if (error_code !== 3'd0) begin failures++; $display("FAIL reset_code: got %0d want 0", error_code); end
        checks++; if (refresh_cnt !== 16'd0) begin failures++; $display("FAIL reset_refresh: got %0d want 0", refresh_cnt); end
    endtask

    task automatic test_init;
        issue(C_PRE, 2'd0, 13'h400);
        issue(C_REF, 2'd0, 13'h000);
        issue(C_REF, 2'd0, 13'h000);
        issue(C_MRS, 2'd0, 13'h230);
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL init_mrs_edge: got %b want 0", init_done); end
        nop(1);
        checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL init_done: got %b want 1", init_done); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL init_error: got %b want 0", error); end
        checks++; if (refresh_cnt !== 16'd0) begin failures++; $display("FAIL init_refresh: got %0d want 0", refresh_cnt); end
    endtask

    task automatic test_write_read;
        issue(C_BACT, 2'd1, 13'h055);
        nop(2);
        write_word(2'd1, 13'h412, 16'hBEEF, 1'b0, 1'b0);
        issue(C_BACT, 2'd1, 13'h055);
        nop(2);
        issue(C_READ, 2'd1, 13'h012);
        checks++; if (dq !== REL) begin failures++; $display("FAIL rd_e0: got %h want %h", dq, REL); end
        nop(1);
        checks++; if (dq !== REL) begin failures++; $display("FAIL rd_e1: got %h want %h", dq, REL); end
        nop(1);
        checks++; if (dq !== 16'hBEEF) begin failures++; $display("FAIL rd_e2: got %h want beef", dq); end
        #8;
        checks++; if (dq !== 16'hBEEF) begin failures++; $display("FAIL rd_pre_e3: got %h want beef", dq); end
        @(posedge clk);
        #1;
        checks++; if (dq !== REL) begin failures++; $display("FAIL rd_e3: got %h want %h", dq, REL); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL rd_error: got %b want 0", error); end
    endtask

    task automatic test_mask;
        write_word(2'd1, 13'h020, 16'h1111, 1'b0, 1'b0);
        write_word(2'd1, 13'h020, 16'hA5C3, 1'b0, 1'b1);
        issue(C_READ, 2'd1, 13'h020);
        nop(2);
        checks++; if (dq !== 16'h11C3) begin failures++; $display("FAIL mask_data: got %h want 11c3", dq); end
        nop(1);
        checks++; if (dq !== REL) begin failures++; $display("FAIL mask_release: got %h want %h", dq, REL); end
    endtask

    task automatic test_back_to_back;
        issue(C_READ, 2'd1, 13'h012);
        issue(C_READ, 2'd1, 13'h020);
        nop(1);
        checks++; if (dq !== 16'hBEEF) begin failures++; $display("FAIL b2b_first: got %h want beef", dq); end
        nop(1);
        checks++; if (dq !== 16'h11C3) begin failures++; $display("FAIL b2b_second: got %h want 11c3", dq); end
        nop(1);
        checks++; if (dq !== REL) begin failures++; $display("FAIL b2b_release: got %h want %h", dq, REL); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL b2b_error: got %b want 0", error); end
    endtask

    task automatic test_closed_bank;
        issue(C_READ, 2'd2, 13'h000);
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL closed_error: got %b want 1", error); end
        checks++; if (error_code !== 3'd4) begin failures++; $display("FAIL closed_code: got %0d want 4", error_code); end
        for (int i = 0; i < 4; i++) begin
            nop(1);
            checks++; if (dq !== REL) begin failures++; $display("FAIL closed_dq%0d: got %h want %h", i, dq, REL); end
        end
        issue(C_BACT, 2'd1, 13'h055);
        checks++; if (error_code !== 3'd4) begin failures++; $display("FAIL closed_sticky_code: got %0d want 4", error_code); end
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL closed_sticky_err: got %b want 1", error); end
    endtask

    task automatic test_init_error;
        rst_n = 1'b0;
        nop(1);
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL ie_reset_err: got %b want 0", error); end
        checks++; if (error_code !== 3'd0) begin failures++; $display("FAIL ie_reset_code: got %0d want 0", error_code); end
        rst_n = 1'b1;
        issue(C_PRE, 2'd0, 13'h400);
        issue(C_REF, 2'd0, 13'h000);
        issue(C_REF, 2'd0, 13'h000);
        issue(C_BACT, 2'd0, 13'h000);
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL ie_error: got %b want 1", error); end
        checks++; if (error_code !== 3'd1) begin failures++; $display("FAIL ie_code: got %0d want 1", error_code); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL ie_init_done: got %b want 0", init_done); end
        issue(C_MRS, 2'd0, 13'h020);
        nop(1);
        checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL ie_cl2_init: got %b want 1", init_done); end
        issue(C_BACT, 2'd0, 13'h000);
        nop(2);
        write_word(2'd0, 13'h012, 16'h1234, 1'b0, 1'b0);
        nop(1);
        issue(C_READ, 2'd0, 13'h012);
        checks++; if (dq !== REL) begin failures++; $display("FAIL cl2_e0: got %h want %h", dq, REL); end
        nop(1);
        checks++; if (dq !== 16'h1234) begin failures++; $display("FAIL cl2_e1: got %h want 1234", dq); end
        #8;
        checks++; if (dq !== 16'h1234) begin failures++; $display("FAIL cl2_pre_e2: got %h want 1234", dq); end
        @(posedge clk);
        #1;
        checks++; if (dq !== REL) begin failures++; $display("FAIL cl2_e2: got %h want %h", dq, REL); end
        checks++; if (error_code !== 3'd1) begin failures++; $display("FAIL ie_sticky_code: got %0d want 1", error_code); end
    endtask

    task automatic test_reset_mid_read;
        issue(C_MRS, 2'd0, 13'h030);
        issue(C_READ, 2'd0, 13'h012);
        nop(2);
        checks++; if (dq !== 16'h1234) begin failures++; $display("FAIL rst_pre_data: got %h want 1234", dq); end
        rst_n = 1'b0;
        #1;
        checks++; if (dq !== REL) begin failures++; $display("FAIL rst_dq: got %h want %h", dq, REL); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL rst_init_done: got %b want 0", init_done); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL rst_error: got %b want 0", error); end
        checks++; if (error_code !== 3'd0) begin failures++; $display("FAIL rst_code: got %0d want 0", error_code); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_trcd_refresh;
        issue(C_PRE, 2'd0, 13'h400);
        issue(C_REF, 2'd0, 13'h000);
        issue(C_REF, 2'd0, 13'h000);
        issue(C_MRS, 2'd0, 13'h230);
        nop(1);
        issue(C_BACT, 2'd3, 13'h000);
        issue(C_READ, 2'd3, 13'h000);
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL trcd_error: got %b want 1", error); end
        checks++; if (error_code !== 3'd5) begin failures++; $display("FAIL trcd_code: got %0d want 5", error_code); end
        nop(3);
        issue(C_REF, 2'd0, 13'h000);
        checks++; if (refresh_cnt !== 16'd1) begin failures++; $display("FAIL ref_count: got %0d want 1", refresh_cnt); end
        checks++; if (error_code !== 3'd5) begin failures++; $display("FAIL ref_sticky_code: got %0d want 5", error_code); end
    endtask

    initial begin
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        test_reset;
        rst_n = 1'b1;
        test_init;
        test_write_read;
        test_mask;
        test_back_to_back;
        test_closed_bank;
        test_init_error;
        test_reset_mid_read;
        test_trcd_refresh;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
